// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder arbiter: default sizes and the requester id type.
// The optional subtract mode is enabled by defining ADDER_ARB_SUB_EN.
package adder_arb_pkg;

    localparam int WIDTH_DEF   = 64;
    localparam int NUM_REQ_DEF = 3;

    typedef logic [1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        logic    cin;
        req_id_t id;
    } o_ctrl_t;

endpackage

// File: rtl/adder_arbiter_cla.sv
// The team's carry-lookahead adder (Kogge-Stone prefix network), 64 bits by default.
// Computes {cout, sum} = a + b + cin.
module cla64 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] gen_l  [LEVELS+1];
    logic [WIDTH-1:0] prop_l [LEVELS+1];
    logic [WIDTH:0]   carry;

    assign gen_l[0]  = a & b;
    assign prop_l[0] = a ^ b;

    // Each level merges (generate, propagate) pairs spanning twice the distance of the previous one.
    for (genvar lvl = 0; lvl < LEVELS; lvl++) begin : g_level
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= (1 << lvl)) begin : g_merge
                assign gen_l[lvl+1][i]  = gen_l[lvl][i] | (prop_l[lvl][i] & gen_l[lvl][i-(1<<lvl)]);
                assign prop_l[lvl+1][i] = prop_l[lvl][i] & prop_l[lvl][i-(1<<lvl)];
            end else begin : g_pass
                assign gen_l[lvl+1][i]  = gen_l[lvl][i];
                assign prop_l[lvl+1][i] = prop_l[lvl][i];
            end
        end
    end

    assign carry = {gen_l[LEVELS] | (prop_l[LEVELS] & {WIDTH{cin}}), cin};
    assign sum   = prop_l[0] ^ carry[WIDTH-1:0];
    assign cout  = carry[WIDTH];

endmodule

// File: rtl/adder_arbiter_rr_grant.sv
// Round-robin grant: picks the first valid requester at or after ptr, wrapping around.
module rr_grant
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] valid,
    input  req_id_t            ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant
);

    logic [2:0] pos;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = '0;
        idx   = '0;
        if (enable) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                pos = {1'b0, ptr} + 3'(off);
                if (pos >= 3'(NUM_REQ)) begin
                    pos = pos - 3'(NUM_REQ);
                end
                idx = pos[1:0];
                if (!found && valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Two-stage shared adder with round-robin arbitration among NUM_REQ requesters.
// Defining ADDER_ARB_SUB_EN adds req_sub, selecting a - b per request.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
`ifdef ADDER_ARB_SUB_EN
    input  logic [NUM_REQ-1:0]       req_sub,
`endif
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output req_id_t                  rsp_id
);

    req_id_t            ptr;
    o_ctrl_t            o_ctrl;
    logic [WIDTH-1:0]   o_a;
    logic [WIDTH-1:0]   o_b;
    logic               r_valid;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    req_id_t            r_id;

    logic               advance_r;
    logic               o_open;
    logic [NUM_REQ-1:0] grant;
    logic               take;
    req_id_t            gnt_id;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               sel_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    // O may take a new request when it is empty or its content moves into R this cycle.
    assign advance_r = !r_valid || rsp_ready;
    assign o_open    = !o_ctrl.valid || advance_r;

    rr_grant #(
        .NUM_REQ (NUM_REQ)
    ) u_grant (
        .valid  (req_valid),
        .ptr    (ptr),
        .enable (o_open && !reset),
        .grant  (grant)
    );

    assign req_ready = grant;
    assign take      = |grant;

    always_comb begin
        gnt_id  = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_id  = 2'(i);
                sel_a   = req_a[i*WIDTH +: WIDTH];
                sel_b   = req_b[i*WIDTH +: WIDTH];
                sel_cin = req_cin[i];
`ifdef ADDER_ARB_SUB_EN
                if (req_sub[i]) begin
                    sel_b   = ~req_b[i*WIDTH +: WIDTH];
                    sel_cin = 1'b1;
                end
`endif
            end
        end
    end

    cla64 #(
        .WIDTH (WIDTH)
    ) u_cla (
        .a    (o_a),
        .b    (o_b),
        .cin  (o_ctrl.cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            o_ctrl  <= '0;
            o_a     <= '0;
            o_b     <= '0;
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_id    <= '0;
        end else begin
            if (advance_r) begin
                r_valid <= o_ctrl.valid;
                if (o_ctrl.valid) begin
                    r_sum  <= add_sum;
                    r_cout <= add_cout;
                    r_id   <= o_ctrl.id;
                end
            end
            if (o_open) begin
                o_ctrl.valid <= take;
                if (take) begin
                    o_a        <= sel_a;
                    o_b        <= sel_b;
                    o_ctrl.cin <= sel_cin;
                    o_ctrl.id  <= gnt_id;
                end
            end
            if (take) begin
                ptr <= (gnt_id == req_id_t'(NUM_REQ - 1)) ? '0 : gnt_id + 2'd1;
            end
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign rsp_id    = r_id;

endmodule
